// File: rtl/sr_alu_mul_pkg.sv
// Shared definitions for the shift-add multiplier sequencer and its ALU.
// Opcode values match the single-cycle core's ALU encodings.
package sr_alu_mul_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SRL = 3'b010;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        DBL  = 3'd2,
        SHR  = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/sr_alu.sv
// Combinational ALU slice exposing the operations the multiplier sequencer uses.
// Opcodes outside ADD/SRL return zero.
module sr_alu
    import sr_alu_mul_pkg::*;
(
    input  logic [31:0] srcA_i,
    input  logic [31:0] srcB_i,
    input  logic [2:0]  oper_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    always_comb begin
        result_o = '0;
        case (oper_i)
            ALU_OP_ADD: result_o = srcA_i + srcB_i;
            ALU_OP_SRL: result_o = srcA_i >> srcB_i[4:0];
            default:    result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/sr_alu_mul_seq.sv
// Multi-cycle 32x32 shift-add multiplier that borrows an external ALU for every add/shift.
// Returns the low 32 bits of req_a * req_b over a valid/ready handshake.
module sr_alu_mul_seq
    import sr_alu_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] alu_srcA,
    output logic [31:0] alu_srcB,
    output logic [2:0]  alu_oper,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    state_e      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        alu_oper = ALU_OP_ADD;
        alu_srcA = '0;
        alu_srcB = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    mcand_d  = req_a;
                    mplier_d = req_b;
                    acc_d    = '0;
                    if (req_b == '0)
                        state_d = DONE;
                    else if (req_b[0])
                        state_d = ACC;
                    else
                        state_d = DBL;
                end
            end
            ACC: begin
                alu_srcA = acc_q;
                alu_srcB = mcand_q;
                acc_d    = alu_result;
                state_d  = DBL;
            end
            DBL: begin
                alu_srcA = mcand_q;
                alu_srcB = mcand_q;
                mcand_d  = alu_result;
                state_d  = SHR;
            end
            SHR: begin
                // Next multiplier bit comes straight off the shifted value.
                alu_oper = ALU_OP_SRL;
                alu_srcA = mplier_q;
                alu_srcB = 32'd1;
                mplier_d = alu_result;
                if (alu_zero)
                    state_d = DONE;
                else if (alu_result[0])
                    state_d = ACC;
                else
                    state_d = DBL;
            end
            DONE: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = rsp_valid ? acc_q : '0;

endmodule
